// File: rtl/example1_sequencer_if.sv
// Control bundle for example1_sequencer: request inputs and registered status outputs.
// The timeout status line exists only when EXAMPLE1_SYNC_TIMEOUT_EN is defined.
interface example1_sequencer_if;
    logic start;
    logic seq;
    logic ext_sync;
    logic running;
    logic done;
`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
    logic timeout;

    modport master (output start, seq, ext_sync, input running, done, timeout);
    modport slave  (input start, seq, ext_sync, output running, done, timeout);
`else
    modport master (output start, seq, ext_sync, input running, done);
    modport slave  (input start, seq, ext_sync, output running, done);
`endif
endinterface

// File: rtl/example1_sequencer.sv
// Two-sequence control sequencer: seq 0 is a fixed 10-cycle run, seq 1 arms then waits for ext_sync.
// Optional feature macro EXAMPLE1_SYNC_TIMEOUT_EN adds a 200-cycle abort of S1_WAIT and a timeout pulse.
module example1_sequencer (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    example1_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        S0_SETUP,
        S0_BODY,
        S0_TEARDOWN,
        S1_ARM,
        S1_WAIT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_step;
    logic [3:0] w_step_next;
    logic       r_running;
    logic       r_done;
    logic       w_exit;
    logic       w_abort;

`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
    logic [7:0] r_wait;
    logic [7:0] w_wait_next;
    logic       r_timeout;
`endif

    // Phase lengths are counted with r_step; it is cleared on every phase change.
    always_comb begin
        w_next      = r_state;
        w_step_next = r_step + 4'd1;
        w_abort     = 1'b0;
`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
        w_wait_next = 8'd0;
`endif
        case (r_state)
            IDLE: begin
                w_step_next = 4'd0;
                if (bus.start) begin
                    w_next = bus.seq ? S1_ARM : S0_SETUP;
                end
            end
            S0_SETUP: begin
                if (r_step == 4'd1) begin
                    w_next      = S0_BODY;
                    w_step_next = 4'd0;
                end
            end
            S0_BODY: begin
                if (r_step == 4'd5) begin
                    w_next      = S0_TEARDOWN;
                    w_step_next = 4'd0;
                end
            end
            S0_TEARDOWN: begin
                if (r_step == 4'd1) begin
                    w_next      = IDLE;
                    w_step_next = 4'd0;
                end
            end
            S1_ARM: begin
                if (r_step == 4'd2) begin
                    w_next      = S1_WAIT;
                    w_step_next = 4'd0;
                end
            end
            S1_WAIT: begin
                w_step_next = 4'd0;
                if (bus.ext_sync) begin
                    w_next = IDLE;
                end
`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
                else if (r_wait == 8'd199) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                end
`endif
            end
            default: begin
                w_next      = IDLE;
                w_step_next = 4'd0;
            end
        endcase
    end

    assign w_exit = (r_state != IDLE) && (w_next == IDLE);

    // Outputs are registered from the next state so they line up with the state edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_step    <= 4'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_step    <= w_step_next;
            r_running <= (w_next != IDLE);
            r_done    <= w_exit;
        end
    end

`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wait    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_wait    <= w_wait_next;
            r_timeout <= w_abort;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused;
    assign w_unused = w_abort;
`endif

    assign bus.running = r_running;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_example1_sequencer.sv
// Randomized scoreboard bench for example1_sequencer; expectations come from the cycle rules of each sequence.
module tb_example1_sequencer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   run_cnt;

    typedef struct {
        int done_edge;
        int dur;
        bit tmo;
    } exp_t;

    exp_t exp_q[$];

    example1_sequencer_if bus ();

    example1_sequencer dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse; run_cnt is the number of sampled-high running cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_cnt = 0;
        end else begin
            if (bus.running) run_cnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_edge", cyc, e.done_edge);
                    check("running_cycles", run_cnt, e.dur);
                    check("running_low_at_done", int'(bus.running), 0);
`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
                    check("timeout_flag", int'(bus.timeout), int'(e.tmo));
`endif
                end
                run_cnt = 0;
            end
`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
            if (bus.timeout && !bus.done) check("timeout_without_done", 1, 0);
`endif
        end
    end

    // k: edge index (relative to E0) where ext_sync is first sampled 1 in S1_WAIT; 0 = never.
    // noise: random start/seq toggles while active and random ext_sync during S1_ARM.
    task automatic run_seq(input bit s, input int k, input bit held, input bit noise);
        int   e0;
        int   d;
        exp_t e;
        @(negedge clk);
        e0 = cyc + 1;
        bus.start    = 1'b1;
        bus.seq      = s;
        bus.ext_sync = held ? 1'b1 : 1'b0;
        if (!s)          d = 10;
        else if (held)   d = 4;
        else if (k == 0) d = 203;
        else             d = k;
        e.done_edge = e0 + d;
        e.dur       = d;
        e.tmo       = s && !held && (k == 0);
        exp_q.push_back(e);
        for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            bus.start = noise ? 1'($urandom_range(1)) : 1'b0;
            bus.seq   = noise ? 1'($urandom_range(1)) : s;
            if (!s)          bus.ext_sync = 1'($urandom_range(1));
            else if (held)   bus.ext_sync = 1'b1;
            else if (j <= 3) bus.ext_sync = noise ? 1'($urandom_range(1)) : 1'b0;
            else             bus.ext_sync = (k != 0) && (j >= k);
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.ext_sync = 1'b0;
        repeat ($urandom_range(2)) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   e0;
        cyc          = 0;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.seq      = 1'b0;
        bus.ext_sync = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_running", int'(bus.running), 0);
        check("reset_done", int'(bus.done), 0);
`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
        check("reset_timeout", int'(bus.timeout), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases from the plan.
        run_seq(1'b0, 0, 1'b0, 1'b0);
        run_seq(1'b1, 16, 1'b0, 1'b0);
        run_seq(1'b1, 0, 1'b1, 1'b0);
        run_seq(1'b0, 0, 1'b0, 1'b1);
        run_seq(1'b1, 4, 1'b0, 1'b1);

        // start held high: second run begins on the edge after done.
        @(negedge clk);
        e0 = cyc + 1;
        bus.start = 1'b1;
        bus.seq   = 1'b0;
        e.done_edge = e0 + 10; e.dur = 10; e.tmo = 1'b0; exp_q.push_back(e);
        e.done_edge = e0 + 21; e.dur = 10; e.tmo = 1'b0; exp_q.push_back(e);
        repeat (12) @(negedge clk);
        bus.start = 1'b0;
        bus.seq   = 1'b1;
        repeat (11) @(negedge clk);

        // Reset mid-sequence: outputs clear at once and no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        bus.seq   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_running", int'(bus.running), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_running", int'(bus.running), 0);
        check("async_reset_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("idle_after_reset", int'(bus.running), 0);

`ifdef EXAMPLE1_SYNC_TIMEOUT_EN
        run_seq(1'b1, 0, 1'b0, 1'b0);
        run_seq(1'b1, 0, 1'b0, 1'b1);
`endif

        // Randomized runs.
        for (int i = 0; i < 30; i++) begin
            bit s;
            s = 1'($urandom_range(1));
            case ($urandom_range(3))
                0:       run_seq(s, 0, 1'b1, 1'($urandom_range(1)));
                default: run_seq(s, int'($urandom_range(30, 4)), 1'b0, 1'($urandom_range(1)));
            endcase
        end

        repeat (5) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
